// File: rtl/keypad_sequencer.sv
// keypad_sequencer: turns a command stream into timed key/button presses for a microwave front panel.
// Define KEYPAD_FIFO_EN to add a 4-entry command FIFO; without it commands are accepted only in IDLE.
module keypad_sequencer #(
    parameter int HOLD_CYCLES = 110,
    parameter int GAP_CYCLES  = 110
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       cmd_valid,
    input  logic [3:0] cmd,
    output logic       cmd_ready,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       stopn,
    output logic       clearn,
    output logic       busy,
    output logic       err
);
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int MAX_EFF  = (HOLD_EFF > GAP_EFF) ? HOLD_EFF : GAP_EFF;
    localparam int CW       = (MAX_EFF < 2) ? 1 : $clog2(MAX_EFF);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_EFF - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_EFF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [3:0]    cur_r, cur_s;
    logic          accept_s, cmd_ok_s;
    logic          avail_s, queued_s, ready_s;
    logic [3:0]    avail_cmd_s;
    logic [9:0]    keypad_s;
    logic          startn_s, stopn_s, clearn_s, busy_s, err_s;

    assign accept_s = cmd_valid && cmd_ready;
    assign cmd_ok_s = (cmd <= 4'd12);

`ifdef KEYPAD_FIFO_EN
    logic [3:0] fifo_r [4];
    logic [1:0] rd_r, wr_r;
    logic [2:0] count_r, count_s;
    logic       push_s, pop_s, start_s;

    // Queue head has priority; an incoming command bypasses the queue only when it is empty
    always_comb begin
        if (count_r != 3'd0) begin
            avail_s     = 1'b1;
            avail_cmd_s = fifo_r[rd_r];
        end else if (accept_s && cmd_ok_s) begin
            avail_s     = 1'b1;
            avail_cmd_s = cmd;
        end else begin
            avail_s     = 1'b0;
            avail_cmd_s = 4'd0;
        end
    end

    assign start_s  = (state_s == HOLD) && (state_r != HOLD);
    assign pop_s    = start_s && (count_r != 3'd0);
    assign push_s   = accept_s && cmd_ok_s && !(start_s && (count_r == 3'd0));
    assign count_s  = count_r + {2'd0, push_s} - {2'd0, pop_s};
    assign queued_s = (count_s != 3'd0);
    assign ready_s  = (count_s != 3'd4);

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_r    <= 2'd0;
            wr_r    <= 2'd0;
            count_r <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_r[wr_r] <= cmd;
                wr_r         <= wr_r + 2'd1;
            end
            if (pop_s) begin
                rd_r <= rd_r + 2'd1;
            end
            count_r <= count_s;
        end
    end
`else
    assign avail_s     = accept_s && cmd_ok_s;
    assign avail_cmd_s = cmd;
    assign queued_s    = 1'b0;
    assign ready_s     = (state_s == IDLE);
`endif

    // Next-state and hold/gap counter logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cur_s   = cur_r;
        case (state_r)
            IDLE: begin
                if (avail_s) begin
                    state_s = HOLD;
                    cnt_s   = {CW{1'b0}};
                    cur_s   = avail_cmd_s;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    state_s = GAP;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_s = {CW{1'b0}};
                    if (avail_s) begin
                        state_s = HOLD;
                        cur_s   = avail_cmd_s;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so outputs can be registered
    always_comb begin
        keypad_s = 10'd0;
        startn_s = 1'b1;
        stopn_s  = 1'b1;
        clearn_s = 1'b1;
        if (state_s == HOLD) begin
            case (cur_s)
                4'd10:   startn_s = 1'b0;
                4'd11:   stopn_s  = 1'b0;
                4'd12:   clearn_s = 1'b0;
                default: begin
                    if (cur_s <= 4'd9) begin
                        keypad_s = 10'd1 << cur_s;
                    end else begin
                        keypad_s = 10'd0;
                    end
                end
            endcase
        end else begin
            keypad_s = 10'd0;
        end
        busy_s = (state_s != IDLE) || queued_s;
        err_s  = accept_s && !cmd_ok_s;
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (clear) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            cur_r     <= 4'd0;
            keypad    <= 10'd0;
            startn    <= 1'b1;
            stopn     <= 1'b1;
            clearn    <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            cur_r     <= cur_s;
            keypad    <= keypad_s;
            startn    <= startn_s;
            stopn     <= stopn_s;
            clearn    <= clearn_s;
            cmd_ready <= ready_s;
            busy      <= busy_s;
            err       <= err_s;
        end
    end
endmodule

// File: tb/tb_keypad_sequencer.sv
// Bench for keypad_sequencer: directed scenarios plus randomized traffic checked against
// a schedule model (each accepted command gets a start slot; outputs follow from the intervals).
module tb_keypad_sequencer;
    localparam int H = 110;
    localparam int G = 110;
    localparam int P = H + G;
`ifdef KEYPAD_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif
    localparam logic [15:0] IDLE_OBS = {10'd0, 3'b111, 1'b0, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       clear, cmd_valid;
    logic [3:0] cmd;
    logic       cmd_ready, startn, stopn, clearn, busy, err;
    logic [9:0] keypad;
    logic [15:0] obs;
    int total = 0;
    int passed = 0;
    int cyc = 0;

    keypad_sequencer #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .keypad(keypad), .startn(startn), .stopn(stopn),
        .clearn(clearn), .busy(busy), .err(err)
    );

    assign obs = {keypad, startn, stopn, clearn, busy, err, cmd_ready};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected {keypad, startn, stopn, clearn} while a command is being held
    function automatic logic [12:0] lines_for(input int code);
        logic [9:0] kp;
        logic [2:0] btn;
        kp  = 10'd0;
        btn = 3'b111;
        if (code < 10) kp[code] = 1'b1;
        else if (code == 10) btn = 3'b011;
        else if (code == 11) btn = 3'b101;
        else if (code == 12) btn = 3'b110;
        return {kp, btn};
    endfunction

    task automatic test_reset();
        clear = 1'b1; cmd_valid = 1'b0; cmd = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== IDLE_OBS) $display("FAIL reset: got %h expected %h", obs, IDLE_OBS);
        else passed++;
        clear = 1'b0;
    endtask

    task automatic test_single(input int code);
        logic [15:0] exp;
        cmd_valid = 1'b1; cmd = 4'(code);
        for (int rel = 0; rel <= P; rel++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd = 4'($urandom_range(0, 15));
            if (rel < H) exp = {lines_for(code), 1'b1, 1'b0, FIFO};
            else if (rel < P) exp = {10'd0, 3'b111, 1'b1, 1'b0, FIFO};
            else exp = IDLE_OBS;
            total++;
            if (obs !== exp) $display("FAIL single_cmd%0d[%0d]: got %h expected %h", code, rel, obs, exp);
            else passed++;
        end
    endtask

    task automatic test_invalid();
        logic [15:0] exp;
        cmd_valid = 1'b1; cmd = 4'(13 + $urandom_range(0, 2));
        for (int rel = 0; rel < 3; rel++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            exp = (rel == 0) ? {10'd0, 3'b111, 1'b0, 1'b1, 1'b1} : IDLE_OBS;
            total++;
            if (obs !== exp) $display("FAIL invalid[%0d]: got %h expected %h", rel, obs, exp);
            else passed++;
        end
    endtask

`ifdef KEYPAD_FIFO_EN
    task automatic test_back_to_back();
        int seq[5] = '{5, 9, 9, 9, 10};
        int k, ph, q;
        logic [15:0] exp;
        for (int rel = -1; rel <= 5 * P; rel++) begin
            if (rel >= 0) begin
                k  = rel / P;
                ph = rel % P;
                q  = ((rel < 4) ? rel : 4) - ((k < 4) ? k : 4);
                if (k < 5 && ph < H) exp = {lines_for(seq[k]), 1'b1, 1'b0, (q < 4)};
                else exp = {10'd0, 3'b111, (rel < 5 * P), 1'b0, (q < 4)};
                total++;
                if (obs !== exp) $display("FAIL fifo_b2b[%0d]: got %h expected %h", rel, obs, exp);
                else passed++;
            end
            if (rel + 1 <= 4) begin
                cmd_valid = 1'b1; cmd = 4'(seq[rel + 1]);
            end else begin
                cmd_valid = 1'b0; cmd = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
    endtask
`else
    task automatic test_back_to_back();
        int ph;
        logic [15:0] exp;
        for (int rel = -1; rel <= 2 * P + 1; rel++) begin
            if (rel >= 0) begin
                if (rel < P) ph = rel;
                else if (rel == P) ph = -1;
                else ph = rel - P - 1;
                if (ph < 0 || ph >= P) exp = IDLE_OBS;
                else if (ph < H) exp = {lines_for(5), 1'b1, 1'b0, 1'b0};
                else exp = {10'd0, 3'b111, 1'b1, 1'b0, 1'b0};
                total++;
                if (obs !== exp) $display("FAIL held_valid[%0d]: got %h expected %h", rel, obs, exp);
                else passed++;
            end
            cmd_valid = (rel + 1 <= P + 1);
            cmd = 4'd5;
            @(negedge clk);
        end
    endtask
`endif

    task automatic test_clear_hold();
        logic [15:0] exp;
        for (int rel = -1; rel <= 350; rel++) begin
            if (rel >= 0) begin
                exp = (rel < 50) ? {lines_for(9), 1'b1, 1'b0, FIFO} : IDLE_OBS;
                total++;
                if (obs !== exp) $display("FAIL clear_hold[%0d]: got %h expected %h", rel, obs, exp);
                else passed++;
            end
            if (rel == -1) begin
                cmd_valid = 1'b1; cmd = 4'd9;
            end else if (FIFO && rel < 2) begin
                cmd_valid = 1'b1; cmd = 4'(3 + rel);
            end else begin
                cmd_valid = 1'b0; cmd = 4'($urandom_range(0, 15));
            end
            clear = (rel == 49);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int acc_q[$], st_q[$], code_q[$], err_q[$];
        int last_end, slot, q, start;
        logic [12:0] ln;
        logic eb, ee, er;
        logic [15:0] exp;
        last_end = 0;
        for (int i = 0; i < 6000; i++) begin
            slot = cyc;
            ln = 13'b0000000000_111; eb = 1'b0; ee = 1'b0; q = 0;
            for (int j = 0; j < st_q.size(); j++) begin
                if (slot >= st_q[j] && slot < st_q[j] + H) ln = lines_for(code_q[j]);
                if (slot >= acc_q[j] && slot < st_q[j] + P) eb = 1'b1;
                if (slot >= acc_q[j] && slot < st_q[j]) q++;
            end
            foreach (err_q[j]) if (err_q[j] == slot) ee = 1'b1;
            er = FIFO ? (q < 4) : !eb;
            exp = {ln, eb, ee, er};
            total++;
            if (obs !== exp) $display("FAIL random[%0d]: got %h expected %h", i, obs, exp);
            else passed++;
            cmd = 4'($urandom_range(0, 15));
            cmd_valid = ($urandom_range(0, 59) == 0);
            if (cmd_valid && er) begin
                if (cmd <= 4'd12) begin
                    start = (slot + 1 > last_end) ? slot + 1 : last_end;
                    acc_q.push_back(slot + 1);
                    st_q.push_back(start);
                    code_q.push_back(int'(cmd));
                    last_end = start + P;
                end else begin
                    err_q.push_back(slot + 1);
                end
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        clear = 1'b1; cmd_valid = 1'b0; cmd = 4'd0;
        test_reset();
        test_single(2);
        test_single(10);
        test_single(11);
        test_single(12);
        test_invalid();
        test_back_to_back();
        test_clear_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/keypad_sequencer.md
KEYPAD_SEQUENCER -- requirements
Module: keypad_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 110, SHALL set the clk cycles a key or button is held active (1100 ms at the 10 ms clk).
REQ-002 Parameter GAP_CYCLES, default 110, SHALL set the clk cycles all keys and buttons are released after each hold.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 clear  input  1  SHALL be the synchronous, active-high reset.
REQ-005 cmd_valid  input  1  SHALL qualify cmd.
REQ-006 cmd  input  4  SHALL carry the command: 0-9 digit, 10 START, 11 STOP, 12 CLEAR, 13-15 invalid.
REQ-007 cmd_ready  output  1  SHALL be high when a command can be accepted.
REQ-008 keypad  output  10  SHALL be the one-hot digit lines to the microwave; bit n means digit n.
REQ-009 startn, stopn, clearn  output  1 each  SHALL be the active-low button lines to the microwave.
REQ-010 busy  output  1  SHALL be high while the block is not IDLE or a command is queued.
REQ-011 err  output  1  SHALL pulse high for one cycle when an invalid command is accepted.

Function
REQ-012 The block SHALL accept a command on any rising edge where cmd_valid and cmd_ready are both high.
REQ-013 The FSM SHALL have three states: IDLE, HOLD and GAP.
REQ-014 IDLE->HOLD SHALL occur when a valid command is available; HOLD->GAP after exactly HOLD_CYCLES cycles; GAP->HOLD after exactly GAP_CYCLES cycles if a command is available, else GAP->IDLE.
REQ-015 In HOLD, exactly one line SHALL be active: keypad bit cmd for digits, startn low for START, stopn low for STOP, clearn low for CLEAR; all other lines SHALL be released.
REQ-016 In IDLE and GAP, keypad SHALL be 0 and startn, stopn and clearn SHALL be 1.
REQ-017 All outputs SHALL be registered; the active line SHALL be driven from the cycle after the accepting edge (latency 1) when starting from IDLE.
REQ-018 An invalid command (13-15) SHALL be accepted and dropped: err high for the following cycle, no hold or gap, state unchanged.
REQ-019 The hold and gap counters SHALL be wide enough for max(HOLD_CYCLES, GAP_CYCLES) with no wrap-around; a value of 0 for either parameter SHALL be treated as 1.
REQ-020 cmd is sampled only at acceptance; changes on cmd during HOLD or GAP SHALL NOT affect the active line.

Reset
REQ-021 While clear is high at a rising edge, the block SHALL enter IDLE with keypad=0, startn=stopn=clearn=1, cmd_ready per REQ-023/024, busy=0, err=0, counters=0 and any queue emptied.
REQ-022 Asserting clear during HOLD or GAP SHALL release all lines on that edge and discard the in-progress and queued commands.

Configuration
REQ-023 With KEYPAD_FIFO_EN defined, a 4-entry command FIFO SHALL be present.
  - cmd_ready = not full.
  - Pop occurs on IDLE->HOLD and GAP->HOLD.
  - Push and pop in the same cycle SHALL both take effect.
  - Invalid commands SHALL never enter the FIFO.
REQ-024 Without KEYPAD_FIFO_EN, there SHALL be no FIFO: cmd_ready is high only in IDLE, and a command accepted in IDLE enters HOLD on the next edge.

Verification
REQ-025 Reset, then cmd=2 accepted with defaults -> keypad=10'h004 for exactly 110 cycles, then 10'h000 for 110 cycles, then IDLE, busy=0.
REQ-026 cmd=10 (START) -> startn=0 for exactly 110 cycles, keypad=0 throughout, stopn=clearn=1.
REQ-027 cmd=14 -> err=1 for exactly one cycle, keypad=0, startn=stopn=clearn=1, busy=0.
REQ-028 With KEYPAD_FIFO_EN, push 5,9,9,9,10 back-to-back -> cmd_ready drops when 4 are queued; outputs in order are keypad 10'h020, 10'h200 (x3), then startn low, each hold separated by 110 released cycles.
REQ-029 Without KEYPAD_FIFO_EN, cmd_valid held high with cmd=5 throughout -> cmd_ready low in HOLD and GAP; the next acceptance occurs only after returning to IDLE.
REQ-030 clear pulsed 50 cycles into the HOLD of digit 9 -> keypad=0 on the next edge, FSM in IDLE, FIFO empty, no further key activity.
